// File: rtl/bcd_display_scanner_pkg.sv
// bcd_display_scanner_pkg: shared FSM states and display constants for the BCD scanner
package bcd_display_scanner_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;
  localparam logic       SEG_OFF = 1'b1;
  localparam logic [3:0] BCD_MAX = 4'd9;
endpackage

// File: rtl/bcd_display_scanner_prescaler.sv
// scan_prescaler: per-slot cycle counter with blank-end and slot-end ticks
module scan_prescaler #(
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int CW           = $clog2(PRESCALE + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic blank_end,
  output logic slot_end
);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES > 0 ? BLANK_CYCLES - 1 : 0);
  logic [CW-1:0] slot_cnt;
  assign slot_end  = slot_cnt == SLOT_LAST;
  assign blank_end = BLANK_CYCLES > 0 && slot_cnt == BLANK_LAST;
  // slot counter wraps at the end of each slot and is held at zero while the scan is stopped
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) slot_cnt <= '0;
    else slot_cnt <= clr || slot_end ? '0 : slot_cnt + 1'b1;
endmodule

// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: time-multiplexes packed BCD digits onto one shared 7-segment bus
module bcd_display_scanner
  import bcd_display_scanner_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int LZB          = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable_i,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic                    load_i,
  output logic [3:0]              digit_code_o,
  output logic                    dp_n_o,
  output logic [NUM_DIGITS-1:0]   anode_n_o,
  output logic                    frame_o
);
  localparam int     IW         = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam state_t SLOT_FIRST = BLANK_CYCLES == 0 ? SHOW : BLANK;
  state_t                  state, state_nxt;
  logic [IW-1:0]           idx, idx_nxt;
  logic [4*NUM_DIGITS-1:0] shadow_v, disp_v;
  logic [NUM_DIGITS-1:0]   shadow_dp, disp_dp, dark;
  logic                    pending, frame_start, clr, blank_end, slot_end, lit;
  logic [3:0]              nib;
  assign clr = !enable_i || state == IDLE;
  assign nib = disp_v[{idx, 2'b00} +: 4];
  assign lit = !dark[idx];
  scan_prescaler #(
    .PRESCALE    (PRESCALE),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .blank_end(blank_end),
    .slot_end (slot_end)
  );
  // digits are dark when invalid BCD, or when they and every higher digit are zero (never digit 0)
  always_comb begin : lzb_mask
    logic lead;
    dark = '0;
    lead = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      lead    = lead && disp_v[4*k +: 4] == 4'd0;
      dark[k] = disp_v[4*k +: 4] > BCD_MAX || (LZB != 0 && k > 0 && lead);
    end
  end
  // state and digit index registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  // next-state: start a frame on enable or after the last digit, advance digits at slot end
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    frame_start = 1'b0;
    if (!enable_i) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
    end else if (state == IDLE || (state == SHOW && slot_end && idx == IW'(NUM_DIGITS - 1))) begin
      frame_start = 1'b1;
      state_nxt   = SLOT_FIRST;
      idx_nxt     = '0;
    end else if (state == SHOW && slot_end) begin
      state_nxt = SLOT_FIRST;
      idx_nxt   = idx + 1'b1;
    end else if (state == BLANK && blank_end) begin
      state_nxt = SHOW;
    end
  end
  // shadow captures loads; display takes the newest value only at frame start so a frame never tears
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      shadow_v  <= '0;
      shadow_dp <= '0;
      disp_v    <= '0;
      disp_dp   <= '0;
      pending   <= 1'b0;
    end else begin
      if (load_i) begin
        shadow_v  <= value_i;
        shadow_dp <= dp_i;
      end
      if (frame_start && load_i) begin
        disp_v  <= value_i;
        disp_dp <= dp_i;
      end else if (frame_start && pending) begin
        disp_v  <= shadow_v;
        disp_dp <= shadow_dp;
      end
      pending <= frame_start ? 1'b0 : pending || load_i;
    end
  // registered outputs: code/dp follow the slot from its first cycle, anode only during SHOW
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      anode_n_o    <= '1;
      dp_n_o       <= SEG_OFF;
      digit_code_o <= '0;
      frame_o      <= 1'b0;
    end else begin
      anode_n_o <= enable_i && state == SHOW && lit ? ~(NUM_DIGITS'(1) << idx) : '1;
      dp_n_o    <= enable_i && state != IDLE && lit ? ~disp_dp[idx] : SEG_OFF;
      if (enable_i && state != IDLE) digit_code_o <= nib;
      frame_o <= frame_start;
    end
endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb_bcd_display_scanner: randomized and directed checks against a frame-level display model
module tb_bcd_display_scanner;
  logic        clk = 1'b0, rst_n = 1'b0, enable_i = 1'b0, load_i = 1'b0;
  logic [15:0] value_i = '0;
  logic [3:0]  dp_i = '0;
  logic [3:0]  digit_code_o, anode_n_o;
  logic        dp_n_o, frame_o;
  wire  [9:0]  obs = {anode_n_o, dp_n_o, digit_code_o, frame_o};
  localparam logic [9:0] RST_OBS = {4'hf, 1'b1, 4'h0, 1'b0};
  int          checks = 0, fails = 0;
  int          m = -1;
  logic [15:0] sh_v = '0, fv = '0;
  logic [3:0]  sh_d = '0, fd = '0, e_code = '0, e_an = 4'hf;
  logic        e_dp = 1'b1, e_fr = 1'b0;
  bit          pend = 1'b0;
  logic [9:0]  expv = RST_OBS;

  always #5 clk = ~clk;

  bcd_display_scanner #(
    .NUM_DIGITS(4), .PRESCALE(8), .BLANK_CYCLES(2), .LZB(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .value_i(value_i), .dp_i(dp_i),
    .load_i(load_i), .digit_code_o(digit_code_o), .dp_n_o(dp_n_o),
    .anode_n_o(anode_n_o), .frame_o(frame_o)
  );

  function automatic bit dark(input logic [15:0] v, input int d);
    return ((v >> (4 * d)) & 16'hf) > 16'd9 || (d > 0 && (v >> (4 * d)) == 16'd0);
  endfunction

  task automatic model_reset();
    m = -1; sh_v = '0; fv = '0; sh_d = '0; fd = '0; pend = 0;
    e_code = '0; e_an = 4'hf; e_dp = 1'b1; e_fr = 1'b0; expv = RST_OBS;
  endtask

  // m counts clock edges since the scan started; slot position q = m-1 due to output registering
  task automatic step(input bit en, input bit ld, input logic [15:0] v, input logic [3:0] d);
    int q, k;
    enable_i = en; load_i = ld; value_i = v; dp_i = d;
    @(posedge clk);
    if (!en) begin
      m = -1; e_an = 4'hf; e_dp = 1'b1; e_fr = 1'b0;
    end else begin
      m = m + 1;
      e_fr = (m % 32) == 0;
      if (m == 0) begin
        e_an = 4'hf; e_dp = 1'b1;
      end else begin
        q = m - 1; k = (q / 8) % 4;
        e_code = 4'((fv >> (4 * k)) & 16'hf);
        e_dp   = dark(fv, k) ? 1'b1 : !fd[k];
        e_an   = (q % 8 >= 2 && !dark(fv, k)) ? ~(4'b1 << k) : 4'hf;
      end
      if (e_fr) begin
        if (ld) begin fv = v; fd = d; end
        else if (pend) begin fv = sh_v; fd = sh_d; end
        pend = 0;
      end
    end
    if (ld) begin
      sh_v = v; sh_d = d;
      if (!(en && e_fr)) pend = 1;
    end
    expv = {e_an, e_dp, e_code, e_fr};
    #1;
    load_i = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (obs !== RST_OBS) begin fails++; $display("FAIL reset_hold obs=%b exp=%b", obs, RST_OBS); end
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, '0, '0);
    checks++;
    if (obs !== expv) begin fails++; $display("FAIL reset_idle obs=%b exp=%b", obs, expv); end
  endtask

  task automatic test_scan();
    step(0, 1, 16'h1234, 4'h0);
    for (int i = 0; i < 70; i++) begin
      step(1, 0, '0, '0);
      checks++;
      if (obs !== expv) begin fails++; $display("FAIL scan m=%0d obs=%b exp=%b", m, obs, expv); end
      if (i == 3) begin
        checks++;
        if ({anode_n_o, digit_code_o} !== 8'hE4) begin
          fails++; $display("FAIL scan_digit0 an/code=%h exp=e4", {anode_n_o, digit_code_o});
        end
      end
      if (i == 32) begin
        checks++;
        if (frame_o !== 1'b1) begin fails++; $display("FAIL scan_frame got=%b exp=1", frame_o); end
      end
    end
  endtask

  task automatic test_tear_free();
    bit done = 0, d1 = 0, d2 = 0;
    for (int i = 0; i < 80; i++) begin
      bit ld = !done && (m % 32) == 9;
      if (ld) done = 1;
      step(1, ld, 16'h5678, 4'h0);
      checks++;
      if (obs !== expv) begin fails++; $display("FAIL tear_mid m=%0d obs=%b exp=%b", m, obs, expv); end
    end
    for (int i = 0; i < 100; i++) begin
      bit l1 = !d1 && (m % 32) == 5;
      bit l2 = d1 && !d2 && (m % 32) == 20;
      if (l1) d1 = 1;
      if (l2) d2 = 1;
      step(1, l1 || l2, l1 ? 16'h1111 : 16'h2222, 4'h0);
      checks++;
      if (obs !== expv) begin fails++; $display("FAIL tear_last m=%0d obs=%b exp=%b", m, obs, expv); end
    end
  endtask

  task automatic test_lzb();
    for (int i = 0; i < 80; i++) begin
      step(1, i == 0, 16'h0050, 4'b0100);
      checks++;
      if (obs !== expv) begin fails++; $display("FAIL lzb_0050 m=%0d obs=%b exp=%b", m, obs, expv); end
    end
    for (int i = 0; i < 80; i++) begin
      step(1, i == 0, 16'h0000, 4'b0100);
      checks++;
      if (obs !== expv) begin fails++; $display("FAIL lzb_0000 m=%0d obs=%b exp=%b", m, obs, expv); end
    end
  endtask

  task automatic test_invalid();
    for (int i = 0; i < 80; i++) begin
      step(1, i == 0, 16'h12A4, 4'b0010);
      checks++;
      if (obs !== expv) begin fails++; $display("FAIL invalid m=%0d obs=%b exp=%b", m, obs, expv); end
    end
  endtask

  task automatic test_enable_drop();
    for (int i = 0; i < 16 && (m % 8) != 4; i++) begin
      step(1, 0, '0, '0);
      checks++;
      if (obs !== expv) begin fails++; $display("FAIL drop_pre m=%0d obs=%b exp=%b", m, obs, expv); end
    end
    step(0, 0, '0, '0);
    checks++;
    if (obs !== expv || anode_n_o !== 4'hf) begin fails++; $display("FAIL drop obs=%b exp=%b", obs, expv); end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, '0, '0);
      checks++;
      if (obs !== expv) begin fails++; $display("FAIL drop_idle obs=%b exp=%b", obs, expv); end
    end
    step(1, 0, '0, '0);
    checks++;
    if (obs !== expv || frame_o !== 1'b1) begin fails++; $display("FAIL reenable_frame obs=%b exp=%b", obs, expv); end
    for (int i = 0; i < 3; i++) begin
      step(1, 0, '0, '0);
      checks++;
      if (obs !== expv) begin fails++; $display("FAIL reenable m=%0d obs=%b exp=%b", m, obs, expv); end
    end
    checks++;
    if (anode_n_o !== 4'b1110) begin fails++; $display("FAIL reenable_digit0 an=%b exp=1110", anode_n_o); end
  endtask

  task automatic test_load_at_frame_start();
    bit done = 0;
    for (int i = 0; i < 70; i++) begin
      bit ld = !done && (m % 32) == 31;
      if (ld) done = 1;
      step(1, ld, 16'h9876, 4'b1010);
      checks++;
      if (obs !== expv) begin fails++; $display("FAIL load_frame m=%0d obs=%b exp=%b", m, obs, expv); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      logic [15:0] v;
      v = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      if ($urandom_range(0, 3) == 0) v = v >> (4 * $urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) v = 16'($urandom);
      step($urandom_range(0, 49) != 0, $urandom_range(0, 15) == 0, v, 4'($urandom));
      checks++;
      if (obs !== expv) begin fails++; $display("FAIL random m=%0d obs=%b exp=%b", m, obs, expv); end
    end
  endtask

  task automatic test_async_reset();
    bit found = 0;
    step(1, 1, 16'h4321, 4'h0);
    for (int i = 0; i < 40 && !found; i++) begin
      step(1, 0, '0, '0);
      checks++;
      if (obs !== expv) begin fails++; $display("FAIL areset_pre m=%0d obs=%b exp=%b", m, obs, expv); end
      found = e_an != 4'hf;
    end
    checks++;
    if (!found) begin fails++; $display("FAIL areset_show never reached obs=%b", obs); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== RST_OBS) begin fails++; $display("FAIL areset_now obs=%b exp=%b", obs, RST_OBS); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, '0, '0);
    checks++;
    if (obs !== expv) begin fails++; $display("FAIL areset_restart obs=%b exp=%b", obs, expv); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_tear_free();
    test_lzb();
    test_invalid();
    test_enable_drop();
    test_load_at_frame_start();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
